// File: rtl/aud_dsp_feeder.sv
// aud_dsp_feeder: fetches 16-bit PCM words from an asynchronous SRAM and presents
// one sample per LRCK frame to the DAC serializer. It supports fast (skip), slow
// zero-order-hold and slow linear-interpolation playback.
`timescale 1ns/1ps
module aud_dsp_feeder #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 20,
    parameter int SPEED_W = 3
) (
    input  logic              i_bclk,
    input  logic              i_rst_n,
    input  logic              i_daclrck,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_fast,
    input  logic              i_slow_0,
    input  logic              i_slow_1,
    input  logic [SPEED_W-1:0] i_speed,
    input  logic [ADDR_W-1:0]  i_end_addr,
    input  logic [DATA_W-1:0]  i_sram_data,
    output logic [ADDR_W-1:0]  o_sram_addr,
    output logic [DATA_W-1:0]  o_dac_data,
    output logic               o_en,
    output logic               o_done,
    output logic [1:0]         o_state
);

    localparam int SW = SPEED_W + 1;          // width of speed factor S (1..2^SPEED_W)
    localparam int PW = DATA_W + SPEED_W + 1; // signed product width for interpolation

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PLAY = 2'd1, ST_PAUSE = 2'd2} state_t;
    typedef enum logic [1:0] {M_NORM, M_FAST, M_SLOW0, M_SLOW1} mode_t;

    state_t              state;
    mode_t               mode_r, in_mode, eff_mode;
    logic [SW-1:0]       s_r, in_s, eff_s, step;
    logic [SPEED_W-1:0]  k;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   prev_r, cur_r;
    logic                lrck_d, frame;
    logic                boundary, at_end;
    logic [ADDR_W:0]     addr_sum;
    logic signed [DATA_W:0] diff;
    logic signed [PW-1:0] diff_x, k_x, s_x, prod, quot;
    logic [DATA_W-1:0]   interp, sample;

    assign frame       = i_daclrck & ~lrck_d;
    assign o_sram_addr = addr;
    assign o_state     = state;

    // Mode/speed decode. The live inputs are used only at a sample boundary (k==0);
    // mid-sample the values latched at that boundary stay in force.
    always_comb begin
        if (i_fast)
            in_mode = M_FAST;
        else if (i_slow_1)
            in_mode = M_SLOW1;
        else if (i_slow_0)
            in_mode = M_SLOW0;
        else
            in_mode = M_NORM;
        in_s     = (in_mode == M_NORM) ? SW'(1) : ({1'b0, i_speed} + SW'(1));
        eff_mode = (k == '0) ? in_mode : mode_r;
        eff_s    = (k == '0) ? in_s : s_r;
        step     = (eff_mode == M_FAST) ? eff_s : SW'(1);
        boundary = (eff_mode == M_NORM) || (eff_mode == M_FAST) ||
                   ({1'b0, k} == (eff_s - SW'(1)));
        addr_sum = {1'b0, addr} + {{(ADDR_W + 1 - SW){1'b0}}, step};
        at_end   = addr_sum > {1'b0, i_end_addr};
    end

    // Linear interpolation: prev + trunc((cur - prev) * k / S). The signed division
    // truncates toward zero, and the result always lies between prev and cur.
    always_comb begin
        diff   = $signed({cur_r[DATA_W-1], cur_r}) - $signed({prev_r[DATA_W-1], prev_r});
        diff_x = {{(PW - DATA_W - 1){diff[DATA_W]}}, diff};
        k_x    = {{(PW - SPEED_W){1'b0}}, k};
        s_x    = {{(PW - SW){1'b0}}, eff_s};
        prod   = diff_x * k_x;
        quot   = prod / s_x;
        interp = prev_r + quot[DATA_W-1:0];
        sample = (eff_mode == M_SLOW1) ? interp : cur_r;
    end

    // Transport FSM plus per-frame sample/address sequencing. The outputs are registered.
    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            mode_r     <= M_NORM;
            s_r        <= '0;
            k          <= '0;
            addr       <= '0;
            prev_r     <= '0;
            cur_r      <= '0;
            lrck_d     <= 1'b0;
            o_dac_data <= '0;
            o_en       <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            lrck_d <= i_daclrck;
            o_done <= 1'b0;
            if (state == ST_PLAY)
                cur_r <= i_sram_data;
            if (i_stop) begin
                state      <= ST_IDLE;
                o_en       <= 1'b0;
                addr       <= '0;
                k          <= '0;
                o_dac_data <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (i_start) begin
                            state      <= ST_PLAY;
                            o_en       <= 1'b1;
                            addr       <= '0;
                            k          <= '0;
                            prev_r     <= '0;
                            o_dac_data <= '0;
                        end
                    end
                    ST_PLAY: begin
                        if (i_pause) begin
                            state <= ST_PAUSE;
                            o_en  <= 1'b0;
                        end else if (frame) begin
                            o_dac_data <= sample;
                            if (k == '0) begin
                                mode_r <= in_mode;
                                s_r    <= in_s;
                            end
                            if (boundary) begin
                                k      <= '0;
                                prev_r <= cur_r;
                                if (at_end) begin
                                    o_done <= 1'b1;
                                    state  <= ST_IDLE;
                                    o_en   <= 1'b0;
                                    addr   <= '0;
                                end else begin
                                    addr <= addr_sum[ADDR_W-1:0];
                                end
                            end else begin
                                k <= k + SPEED_W'(1);
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (i_start) begin
                            state <= ST_PLAY;
                            o_en  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        o_en  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aud_dsp_feeder.sv
// Testbench for aud_dsp_feeder. The reference model builds the whole expected
// per-frame sample list from the SRAM contents and the playback mode.
`timescale 1ns/1ps
module tb_aud_dsp_feeder;

    logic        bclk = 1'b0;
    logic        rst_n;
    logic        daclrck;
    logic        start, pause, stop, fast, slow_0, slow_1;
    logic [2:0]  speed;
    logic [19:0] end_addr;
    logic [15:0] sram_data;
    logic [19:0] sram_addr;
    logic [15:0] dac_data;
    logic        en, done;
    logic [1:0]  state;

    logic [15:0] mem [64];
    int          done_cnt = 0;
    int          vectors = 0;
    int          miscompares = 0;

    assign sram_data = mem[sram_addr[5:0]];

    aud_dsp_feeder #(.DATA_W(16), .ADDR_W(20), .SPEED_W(3)) dut (
        .i_bclk(bclk), .i_rst_n(rst_n), .i_daclrck(daclrck),
        .i_start(start), .i_pause(pause), .i_stop(stop),
        .i_fast(fast), .i_slow_0(slow_0), .i_slow_1(slow_1),
        .i_speed(speed), .i_end_addr(end_addr), .i_sram_data(sram_data),
        .o_sram_addr(sram_addr), .o_dac_data(dac_data), .o_en(en),
        .o_done(done), .o_state(state)
    );

    always #5 bclk = ~bclk;

    // Frame clock: 20 bclk low, 20 bclk high; changes away from the active edge.
    initial begin
        daclrck = 1'b0;
        forever begin
            repeat (20) @(negedge bclk);
            daclrck = ~daclrck;
        end
    end

    always @(negedge bclk) if (done === 1'b1) done_cnt++;

    initial begin
        #900000;
        $display("FAIL watchdog: run exceeded time limit, got=%0t limit=900000", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic pulse(input bit s_start, input bit s_pause, input bit s_stop);
        start = s_start; pause = s_pause; stop = s_stop;
        @(negedge bclk);
        start = 1'b0; pause = 1'b0; stop = 1'b0;
    endtask

    // Wait for the next frame's stable point, which lies in the LRCK-low half.
    task automatic next_frame();
        @(negedge daclrck);
        @(negedge bclk);
    endtask

    // mode: 0 normal, 1 fast, 2 slow hold, 3 slow interpolate.
    task automatic set_mode(input int mode, input int spd, input int endw, input bit noise);
        fast     = (mode == 1);
        slow_1   = (mode == 3) || (mode == 1 && noise && $urandom_range(0, 1) == 1);
        slow_0   = (mode == 2) || (mode != 0 && mode != 2 && noise && $urandom_range(0, 1) == 1);
        speed    = 3'(spd);
        end_addr = 20'(endw);
    endtask

    // Expected frame sequence, derived directly from the playback rules.
    task automatic build_expected(input int mode, input int spd, input int endw,
                                  output int q[$]);
        int s, idx, prev, cur;
        q = {};
        s = (mode == 0) ? 1 : spd + 1;
        if (mode <= 1) begin
            idx = 0;
            forever begin
                q.push_back(int'($signed(mem[idx])));
                if (idx + s > endw) break;
                idx += s;
            end
        end else if (mode == 2) begin
            for (int w = 0; w <= endw; w++)
                for (int j = 0; j < s; j++) q.push_back(int'($signed(mem[w])));
        end else begin
            prev = 0;
            for (int w = 0; w <= endw; w++) begin
                cur = int'($signed(mem[w]));
                for (int j = 0; j < s; j++) q.push_back(prev + ((cur - prev) * j) / s);
                prev = cur;
            end
        end
    endtask

    task automatic play_run(input int mode, input int spd, input int endw, input bit noise);
        int q[$];
        int base;
        bit last;
        set_mode(mode, spd, endw, noise);
        build_expected(mode, spd, endw, q);
        next_frame();
        pulse(1'b1, 1'b0, 1'b0);
        check("start_en", en, 1);
        check("start_state", state, 1);
        base = done_cnt;
        for (int n = 0; n < q.size(); n++) begin
            next_frame();
            last = (n == q.size() - 1);
            check("frame_data", $signed(dac_data), q[n]);
            check("frame_done", done_cnt - base, last ? 1 : 0);
            check("frame_en", en, last ? 0 : 1);
        end
        check("end_addr0", sram_addr, 0);
        check("end_state", state, 0);
        next_frame();
        check("idle_hold", $signed(dac_data), q[q.size() - 1]);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
        fast = 1'b0; slow_0 = 1'b0; slow_1 = 1'b0; speed = '0; end_addr = '0;
        for (int i = 0; i < 64; i++) mem[i] = 16'(i * 100);
        repeat (3) @(negedge bclk);
        check("rst_data", dac_data, 0);
        check("rst_en", en, 0);
        check("rst_done", done, 0);
        check("rst_state", state, 0);
        check("rst_addr", sram_addr, 0);
        rst_n = 1'b1;

        // Directed examples
        play_run(0, 5, 3, 1'b0);          // normal: 0,100,200,300
        play_run(1, 3, 10, 1'b0);         // fast S=4: [0],[4],[8]
        mem[0] = 16'd10; mem[1] = 16'd20;
        play_run(2, 2, 1, 1'b0);          // slow hold S=3
        mem[0] = 16'd1000; mem[1] = 16'hFC18;  // -1000
        play_run(3, 3, 1, 1'b0);          // slow interp S=4
        play_run(0, 0, 0, 1'b0);          // end address 0: single word
        play_run(3, 0, 2, 1'b0);          // interp with S=1

        // Randomized playback
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
            play_run(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 7)), 1'b1);
        end

        // Pause after F2 for 5 frames, then resume
        for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
        set_mode(0, 0, 7, 1'b0);
        next_frame();
        pulse(1'b1, 1'b0, 1'b0);
        next_frame();
        check("p_f1", $signed(dac_data), $signed(mem[0]));
        next_frame();
        check("p_f2", $signed(dac_data), $signed(mem[1]));
        pulse(1'b0, 1'b1, 1'b0);
        check("p_state", state, 2);
        check("p_en", en, 0);
        check("p_addr", sram_addr, 2);
        for (int f = 0; f < 5; f++) begin
            next_frame();
            check("p_hold_data", $signed(dac_data), $signed(mem[1]));
            check("p_hold_addr", sram_addr, 2);
            check("p_hold_en", en, 0);
        end
        pulse(1'b1, 1'b0, 1'b0);
        check("p_resume_state", state, 1);
        next_frame();
        check("p_resume_data", $signed(dac_data), $signed(mem[2]));
        pulse(1'b0, 1'b0, 1'b1);
        check("stop_data", dac_data, 0);
        check("stop_state", state, 0);
        check("stop_addr", sram_addr, 0);

        // Stop and start together during PLAY: stop wins
        mem[0] = 16'h1234; mem[1] = 16'h2345; mem[2] = 16'h3456;
        next_frame();
        pulse(1'b1, 1'b0, 1'b0);
        next_frame();
        check("ss_f1", dac_data, 16'h1234);
        pulse(1'b1, 1'b0, 1'b1);
        check("ss_state", state, 0);
        check("ss_data", dac_data, 0);
        check("ss_en", en, 0);
        next_frame();
        check("ss_idle_data", dac_data, 0);

        // Asynchronous reset in the middle of a frame
        pulse(1'b1, 1'b0, 1'b0);
        next_frame();
        next_frame();
        check("r_pre_data", dac_data, 16'h2345);
        @(posedge bclk);
        #2 rst_n = 1'b0;
        #1;
        check("r_data", dac_data, 0);
        check("r_en", en, 0);
        check("r_state", state, 0);
        check("r_addr", sram_addr, 0);
        @(negedge bclk);
        rst_n = 1'b1;
        next_frame();
        check("r_after_state", state, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
